aes_decrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_decrypt_iter_if.sv | 25 ++
 rtl/aes_inv_round.sv | 33 +++
 rtl/aes_decrypt_iter.sv | 81 ++++++++
 tb/tb_aes_decrypt_iter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions: S-boxes, GF(2^8) helpers, block constants
// and the iterative-core FSM state type.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLK_W   = 128;
    localparam int N_BYTES = BLK_W / 8;
    localparam logic [3:0] RK_LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // One column of InvMixColumns; byte 0 of the column is in [31:24].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = c;
        b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
           ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
           ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
           ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
           ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Block-in / key-fetch / block-out handshake bundle of the
// iterative AES decryption core.
interface aes_decrypt_iter_if;
    import aes_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [0:BLK_W-1] in_data;
    logic [3:0]       rk_idx;
    logic [0:BLK_W-1] rk;
    logic             out_valid;
    logic             out_ready;
    logic [0:BLK_W-1] out_data;

    modport master (
        output in_valid, in_data, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and, except on the last round, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [0:BLK_W-1] state_i,
    input  logic [0:BLK_W-1] rk_i,
    input  logic             is_final_i,
    output logic [0:BLK_W-1] state_o
);

    logic [0:BLK_W-1] sub_w;
    logic [0:BLK_W-1] ark_w;
    logic [0:BLK_W-1] mix_w;

    // Byte (row r, col c) lives at index 4*c+r; row r rotates right by r.
    always_comb begin
        sub_w = '0;
        mix_w = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_w[(c*4+r)*8 +: 8] =
                    INV_SBOX[state_i[(((c+4-r)%4)*4+r)*8 +: 8]];
            end
        end
        ark_w = sub_w ^ rk_i;
        for (int c = 0; c < 4; c++) begin
            mix_w[c*32 +: 32] = inv_mix_col(ark_w[c*32 +: 32]);
        end
        state_o = is_final_i ? ark_w : mix_w;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round
// keys K10..K0 fetched from an external store via rk_idx.
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    aes_decrypt_iter_if.slave bus
);

    state_e           fsm_q;
    logic [3:0]       round_q;
    logic [3:0]       rk_idx_q;
    logic [0:BLK_W-1] state_q;
    logic [0:BLK_W-1] out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [0:BLK_W-1] rnd_w;

    aes_inv_round u_round (
        .state_i    (state_q),
        .rk_i       (bus.rk),
        .is_final_i (fsm_q == FINAL),
        .state_o    (rnd_w)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.out_data  = out_q;

    // Block sequencing; rk_idx is registered one cycle ahead of use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            rk_idx_q    <= RK_LAST;
            state_q     <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= bus.in_data ^ bus.rk;
                        round_q    <= 4'(NR - 1);
                        rk_idx_q   <= 4'(NR - 1);
                        in_ready_q <= 1'b0;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= rnd_w;
                    if (round_q == 4'd1) begin
                        rk_idx_q <= 4'd0;
                        fsm_q    <= FINAL;
                    end else begin
                        round_q  <= round_q - 4'd1;
                        rk_idx_q <= round_q - 4'd1;
                    end
                end
                FINAL: begin
                    out_q       <= rnd_w;
                    out_valid_q <= 1'b1;
                    rk_idx_q    <= RK_LAST;
                    fsm_q       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, handshake timing,
// reset behaviour and a reference-encryptor round trip.
module tb_aes_decrypt_iter;
    import aes_pkg::*;

    localparam logic [0:127] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PC1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PB  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;

    aes_decrypt_iter_if bus();

    aes_decrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [0:127] rks [0:10];
    logic [0:127] sb [$];
    int           acc_q [$];
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int last_acc = 0;
    int last_gap = 0;
    bit ov_prev = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Combinational key store
    assign bus.rk = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic set_key(input logic [0:127] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]],
                     SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
                rc = m2(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] aes_enc(input logic [0:127] pt);
        logic [0:127] s;
        logic [0:127] t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rks[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[(c*4+r)*8 +: 8] = SBOX[s[(((c+r)%4)*4+r)*8 +: 8]];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = t[c*32 +: 32];
                    t[c*32 +: 32] = {
                        m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3,
                        a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3,
                        a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3,
                        m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3)};
                end
            end
            s = t ^ rks[rnd];
        end
        return s;
    endfunction

    // Monitor: accept timestamps, latency, scoreboard pops
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                if (n_acc > 0) last_gap = cyc - last_acc;
                last_acc = cyc;
                n_acc++;
                acc_q.push_back(cyc);
            end
            if (bus.out_valid && !ov_prev) begin
                if (acc_q.size() > 0)
                    check("latency", 128'(cyc - acc_q.pop_front()), 128'(11));
                else
                    check("spurious_valid", 128'(bus.out_valid), 128'(0));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() > 0)
                    check("out_data", bus.out_data, sb.pop_front());
                else
                    check("spurious_out", 128'(bus.out_valid), 128'(0));
            end
            ov_prev = bus.out_valid;
        end
    end

    function automatic logic [0:127] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [0:127] ct, input logic [0:127] pt);
        int t;
        sb.push_back(pt);
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 40);
        check("accept", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = junk();
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int a0;
        logic [0:127] key;
        logic [0:127] pt;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        set_key(KC1);

        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 C.1
        bus.out_ready = 1'b1;
        send(CC1, PC1);
        drain(30);

        // FIPS-197 Appendix B with rk_idx sequence
        set_key(KB);
        sb.push_back(PB);
        bus.in_valid = 1'b1;
        bus.in_data  = CB;
        @(negedge clk);
        check("rk_idx_idle", 128'(bus.rk_idx), 128'(10));
        check("in_ready_idle", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = junk();
        for (int k = 9; k >= 0; k--) begin
            @(negedge clk);
            check("rk_idx_seq", 128'(bus.rk_idx), 128'(k));
            check("in_ready_busy", 128'(bus.in_ready), 128'(0));
        end
        drain(20);

        // Backpressure
        set_key(KC1);
        bus.out_ready = 1'b0;
        send(CC1, PC1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 30);
        check("bp_valid_seen", 128'(bus.out_valid), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = junk();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, PC1);
            check("bp_hold_valid", 128'(bus.out_valid), 128'(1));
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_in_ready_after", 128'(bus.in_ready), 128'(1));
        check("bp_sb_empty", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;

        // Back-to-back
        sb.push_back(PC1);
        sb.push_back(PC1);
        a0 = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = CC1;
        t = 0;
        while (n_acc < a0 + 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = junk();
        check("b2b_accepts", 128'(n_acc - a0), 128'(2));
        check("b2b_gap", 128'(last_gap), 128'(12));
        drain(30);

        // Reset mid-block
        send(CC1, PC1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.rk_idx != 4'd5 && t < 20);
        check("mid_rk5", 128'(bus.rk_idx), 128'(5));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_out_data", bus.out_data, 128'(0));
        check("mid_rk_idx", 128'(bus.rk_idx), 128'(10));
        check("mid_in_ready", 128'(bus.in_ready), 128'(1));
        sb.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        repeat (15) @(negedge clk);
        check("post_rst_quiet", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;
        set_key(KB);
        send(CB, PB);
        drain(20);

        // Round trip against reference encryptor
        for (int n = 0; n < 100; n++) begin
            key = junk();
            pt  = junk();
            set_key(key);
            send(aes_enc(pt), pt);
            drain(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
